instr_byte_fifo: RTL and testbench

- Front-end stage of the pin-driven register-machine core.
- Captures instruction/immediate bytes presented on the dedicated input pins, qualified by a host strobe.
- Buffers the bytes in a small FIFO and hands them one per cycle to the downstream opcode decoder over a valid/ready handshake.
- Decouples the slow, asynchronous host pin protocol from the decoder's two-cycle MOV-immediate sequence.

---
 rtl/instr_byte_fifo.sv | 102 ++++++++++
 tb/tb_instr_byte_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_byte_fifo.sv
// Host-pin byte capture FIFO feeding the opcode decoder over valid/ready.
// Define INSTR_FIFO_SYNC_EN to put a two-flop synchronizer on in_strobe.
module instr_byte_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_strobe,
    input  logic              clear,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic              s_cur;
    logic              s_prev_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q,  level_d;
    logic              ovf_q,    ovf_d;
    logic [7:0]        mem [DEPTH];

    logic push, pop, full, wr_en, drop;

`ifdef INSTR_FIFO_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], in_strobe};
    end

    assign s_cur = sync_q[1];
`else
    assign s_cur = in_strobe;
`endif

    // Edge detector keeps running through clear so a held strobe never re-pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s_prev_q <= 1'b0;
        else        s_prev_q <= s_cur;
    end

    assign push  = s_cur & ~s_prev_q;
    assign full  = (level_q == FULL_LVL);
    assign pop   = out_valid & out_ready;
    assign wr_en = push & (~full | pop) & ~clear;
    assign drop  = push & full & ~pop & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({wr_en, pop})
                2'b10:   level_d = level_q + (ADDR_W+1)'(1);
                2'b01:   level_d = level_q - (ADDR_W+1)'(1);
                default: level_d = level_q;
            endcase
            if (drop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is never reset; out_data gating hides stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_data;
    end

    assign out_valid = (level_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : 8'h00;
    assign level     = level_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_instr_byte_fifo.sv
// Scoreboard bench for instr_byte_fifo: queue reference model plus per-cycle monitor.
module tb_instr_byte_fifo;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef INSTR_FIFO_SYNC_EN
    localparam int LAT  = 2;
    localparam int MINH = 3;
`else
    localparam int LAT  = 0;
    localparam int MINH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_strobe = 1'b0;
    logic          clear = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [AW:0]   level;
    logic          overflow;

    always #5 clk = ~clk;

    instr_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_strobe(in_strobe),
        .clear(clear), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .overflow(overflow)
    );

    int checks = 0;
    int errors = 0;

    byte unsigned exp_q[$];
    bit           exp_ovf;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: strobe seen LAT samples late, rising edge pushes one byte.
    initial begin
        bit hist[$];
        bit prev_s, s, push, pop;
        int n;
        prev_s = 0;
        exp_ovf = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                hist.delete();
                exp_ovf = 0;
                prev_s  = 0;
            end else begin
                hist.push_back(in_strobe);
                s = (hist.size() > LAT) ? hist.pop_front() : 1'b0;
                push   = s && !prev_s;
                prev_s = s;
                pop    = (exp_q.size() > 0) && out_ready;
                if (clear) begin
                    exp_q.delete();
                    exp_ovf = 0;
                end else begin
                    n = exp_q.size();
                    if (pop) void'(exp_q.pop_front());
                    if (push) begin
                        if (n < DEPTH || pop) exp_q.push_back(in_data);
                        else                  exp_ovf = 1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model every cycle, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("level", int'(level), exp_q.size());
                chk("overflow", int'(overflow), int'(exp_ovf));
                chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
                if (exp_q.size() > 0)
                    chk((out_ready ? "deliver" : "head"), int'(out_data), int'(exp_q[0]));
                else
                    chk("out_data_empty", int'(out_data), 0);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int hi, input int lo);
        in_data   = d;
        in_strobe = 1'b1;
        step(hi);
        in_strobe = 1'b0;
        step(lo);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        int ph_cnt;
        step(2);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(1);

        // Two bytes buffered, then drained in order
        send(8'h31, MINH, MINH);
        send(8'h5A, MINH, MINH);
        step(LAT + 2);
        chk("t1_level", int'(level), 2);
        chk("t1_head", int'(out_data), 'h31);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        step(1);
        chk("t1_empty_valid", int'(out_valid), 0);
        chk("t1_empty_data", int'(out_data), 0);

        // Long strobe counts once
        in_data = 8'hAA;
        in_strobe = 1'b1;
        step(10);
        in_strobe = 1'b0;
        step(MINH + LAT);
        chk("t2_level", int'(level), 1);
        pulse_clear();
        chk("t2_clear_level", int'(level), 0);

        // Overflow on full, sticky across drain
        for (int i = 0; i < 8; i++) send(8'(i), MINH, MINH);
        send(8'hFF, MINH, MINH);
        step(LAT + 1);
        chk("t3_level", int'(level), 8);
        chk("t3_ovf", int'(overflow), 1);
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;
        chk("t3_ovf_sticky", int'(overflow), 1);
        chk("t3_drained", int'(level), 0);
        pulse_clear();

        // Push and pop together while full
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), MINH, MINH);
        step(LAT + 1);
        in_data = 8'h99;
        in_strobe = 1'b1;
        step(LAT);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t4_level", int'(level), 8);
        chk("t4_ovf", int'(overflow), 0);
        step(MINH);
        in_strobe = 1'b0;
        step(MINH);
        out_ready = 1'b1;
        step(10);
        out_ready = 1'b0;

        // Pointer wrap with continuous draining
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send(8'($urandom), MINH, MINH);
        step(LAT + 2);
        out_ready = 1'b0;
        send(8'h11, MINH, MINH);
        send(8'h22, MINH, MINH);
        step(LAT + 1);
        // clear coincides with the push edge; the push must vanish
        in_data = 8'h77;
        in_strobe = 1'b1;
        step(LAT);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t5_level", int'(level), 0);
        chk("t5_valid", int'(out_valid), 0);
        chk("t5_ovf", int'(overflow), 0);
        step(MINH);
        in_strobe = 1'b0;
        step(MINH + LAT);
        chk("t5_no_repush", int'(level), 0);

        // Randomised traffic
        ph_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            if (ph_cnt == 0) begin
                in_strobe = ~in_strobe;
                if (in_strobe) in_data = 8'($urandom);
                ph_cnt = $urandom_range(MINH, MINH + 3);
            end
            ph_cnt--;
            if ((c / 200) % 2 == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                    out_ready = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 149) == 0);
            step(1);
        end
        clear = 1'b0;
        out_ready = 1'b0;
        in_strobe = 1'b0;
        step(MINH + LAT);

        // Asynchronous reset mid-burst, strobe held through release
        send(8'h01, MINH, MINH);
        send(8'h02, MINH, MINH);
        in_data = 8'hC3;
        in_strobe = 1'b1;
        step(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_ovf", int'(overflow), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(LAT + 2);
        chk("t7_held_push", int'(level), 1);
        in_strobe = 1'b0;
        step(MINH + LAT + 2);
        chk("t7_once", int'(level), 1);
        chk("t7_data", int'(out_data), 'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
